// File: rtl/reset_sequencer.sv
// reset_sequencer: synchronises the board reset, holds every reset domain
// through the BRAM warm-up window, then releases memory, peripherals and
// CPU in order. Also runs a CPU-requested soft reset that skips the warm-up.
module reset_sequencer #(
    parameter int SYNC_STAGES   = 2,
    parameter int WARMUP_CYCLES = 65535,
    parameter int STAGE_GAP     = 16,
    parameter int SOFT_HOLD     = 256
) (
    input  logic       clock_in,
    input  logic       reset_ext,
    input  logic       soft_reset_req,
    output logic       mem_resetn,
    output logic       periph_resetn,
    output logic       cpu_resetn,
    output logic       ready,
    output logic [1:0] reset_cause
);

    typedef enum logic [2:0] {
        S_SYNC,
        S_WARMUP,
        S_REL_MEM,
        S_REL_PERIPH,
        S_RUN,
        S_SOFT
    } state_e;

    localparam logic [1:0] CAUSE_EXT  = 2'b01;
    localparam logic [1:0] CAUSE_SOFT = 2'b10;

    // One shared down-counter sized for the longest hold; the extra bit
    // keeps the load values clear of the top of the range.
    localparam int MAX_WG  = (WARMUP_CYCLES > STAGE_GAP) ? WARMUP_CYCLES : STAGE_GAP;
    localparam int MAX_CNT = (MAX_WG > SOFT_HOLD) ? MAX_WG : SOFT_HOLD;
    localparam int CNT_W   = $clog2(MAX_CNT) + 1;

    // Each hold lasts (load + 1) edges including the edge that leaves it.
    localparam logic [CNT_W-1:0] WARM_LOAD = CNT_W'(WARMUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(STAGE_GAP - 1);
    localparam logic [CNT_W-1:0] SOFT_LOAD = CNT_W'(SOFT_HOLD - 1);

    // The SYNC->WARMUP transition of the state register acts as the final
    // synchroniser stage, so only SYNC_STAGES-1 dedicated flops are needed
    // for the deassertion to take exactly SYNC_STAGES edges.
    localparam int SYNC_W = SYNC_STAGES - 1;

    logic [SYNC_W-1:0] sync_q;
    logic              sync_done;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              mem_q, mem_d;
    logic              periph_q, periph_d;
    logic              cpu_q, cpu_d;
    logic              ready_q, ready_d;
    logic [1:0]        cause_q, cause_d;

    // Deassertion synchroniser: shifts in ones once reset_ext is high.
    always_ff @(posedge clock_in or negedge reset_ext) begin
        if (!reset_ext) begin
            sync_q <= '0;
        end else begin
            // NOTE: sequential state is always assigned with <= so every flop
            // samples the pre-edge value of its neighbours.
            sync_q <= SYNC_W'({sync_q, 1'b1});
        end
    end

    assign sync_done = sync_q[SYNC_W-1];

    // State and counter register.
    always_ff @(posedge clock_in or negedge reset_ext) begin
        if (!reset_ext) begin
            state_q <= S_SYNC;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and counter logic; the counter reloads on every state entry.
    always_comb begin
        // NOTE: defaults first so every path assigns both signals and no
        // latch is inferred.
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_SYNC: begin
                if (sync_done) begin
                    state_d = S_WARMUP;
                    cnt_d   = WARM_LOAD;
                end
            end
            S_WARMUP: begin
                if (cnt_q == '0) begin
                    state_d = S_REL_MEM;
                    cnt_d   = GAP_LOAD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_REL_MEM: begin
                if (cnt_q == '0) begin
                    state_d = S_REL_PERIPH;
                    cnt_d   = GAP_LOAD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_REL_PERIPH: begin
                if (cnt_q == '0) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_RUN: begin
                if (soft_reset_req) begin
                    state_d = S_SOFT;
                    cnt_d   = SOFT_LOAD;
                end
            end
            S_SOFT: begin
                if (cnt_q == '0) begin
                    state_d = S_REL_MEM;
                    cnt_d   = GAP_LOAD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = S_SYNC;
                cnt_d   = '0;
            end
        endcase
    end

    // Output decode from the next state so the registered outputs change on
    // the same edge as the state they describe.
    always_comb begin
        mem_d    = (state_d == S_REL_MEM) || (state_d == S_REL_PERIPH) || (state_d == S_RUN);
        periph_d = (state_d == S_REL_PERIPH) || (state_d == S_RUN);
        cpu_d    = (state_d == S_RUN);
        ready_d  = (state_d == S_RUN);
        cause_d  = cause_q;
        if ((state_q == S_RUN) && (state_d == S_SOFT)) begin
            cause_d = CAUSE_SOFT;
        end
    end

    // Output register: every output is a flop, cleared asynchronously.
    always_ff @(posedge clock_in or negedge reset_ext) begin
        if (!reset_ext) begin
            mem_q    <= 1'b0;
            periph_q <= 1'b0;
            cpu_q    <= 1'b0;
            ready_q  <= 1'b0;
            cause_q  <= CAUSE_EXT;
        end else begin
            mem_q    <= mem_d;
            periph_q <= periph_d;
            cpu_q    <= cpu_d;
            ready_q  <= ready_d;
            cause_q  <= cause_d;
        end
    end

    assign mem_resetn    = mem_q;
    assign periph_resetn = periph_q;
    assign cpu_resetn    = cpu_q;
    assign ready         = ready_q;
    assign reset_cause   = cause_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer with short parameters. Each vector
// compares {mem, periph, cpu, ready, cause[1:0]} against hand-computed
// release edges.
module tb_reset_sequencer;

    logic       clock_in;
    logic       reset_ext;
    logic       soft_reset_req;
    logic       mem_resetn;
    logic       periph_resetn;
    logic       cpu_resetn;
    logic       ready;
    logic [1:0] reset_cause;

    int n_vec;
    int n_err;

    logic [5:0] obs;
    assign obs = {mem_resetn, periph_resetn, cpu_resetn, ready, reset_cause};

    reset_sequencer #(
        .SYNC_STAGES  (2),
        .WARMUP_CYCLES(8),
        .STAGE_GAP    (4),
        .SOFT_HOLD    (5)
    ) dut (
        .clock_in      (clock_in),
        .reset_ext     (reset_ext),
        .soft_reset_req(soft_reset_req),
        .mem_resetn    (mem_resetn),
        .periph_resetn (periph_resetn),
        .cpu_resetn    (cpu_resetn),
        .ready         (ready),
        .reset_cause   (reset_cause)
    );

    initial clock_in = 1'b0;
    always #5 clock_in = ~clock_in;

    task automatic check(input string tag, input logic [5:0] got, input logic [5:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got {mem,per,cpu,rdy,cause}=%b expected %b", tag, got, exp);
        end
    endtask

    // Steps edges first..last. soft_reset_req is high for edges in
    // [req_on, req_off). After edge e the expected outputs are
    // mem = e>=m, periph = e>=p, cpu/ready = e>=c, cause constant.
    task automatic expect_seq(input string tag, input int first, input int last,
                              input int m, input int p, input int c,
                              input logic [1:0] cause, input int req_on, input int req_off);
        logic [5:0] exp;
        for (int e = first; e <= last; e++) begin
            soft_reset_req = (e >= req_on) && (e < req_off);
            @(posedge clock_in);
            #1;
            exp = {(e >= m), (e >= p), (e >= c), (e >= c), cause};
            check($sformatf("%s@%0d", tag, e), obs, exp);
        end
        soft_reset_req = 1'b0;
    endtask

    localparam logic [5:0] ALL_ZERO_EXT = 6'b0000_01;
    localparam logic [1:0] C_EXT  = 2'b01;
    localparam logic [1:0] C_SOFT = 2'b10;

    initial begin
        n_vec          = 0;
        n_err          = 0;
        reset_ext      = 1'b1;
        soft_reset_req = 1'b0;

        // Test 1: power-on reset held 3 cycles, then ordered release.
        #1 reset_ext = 1'b0;
        #1 check("por_async", obs, ALL_ZERO_EXT);
        repeat (3) @(posedge clock_in);
        #1 check("por_held", obs, ALL_ZERO_EXT);
        reset_ext = 1'b1;
        expect_seq("t1_ext", 1, 20, 10, 14, 18, C_EXT, 99, 99);

        // Test 2: one-cycle soft request in RUN, no warm-up.
        expect_seq("t2_soft", 0, 15, 5, 9, 13, C_SOFT, 0, 1);

        // Test 3: soft requests during WARMUP..REL_PERIPH are ignored.
        #2 reset_ext = 1'b0;
        #1 check("t3_clr", obs, ALL_ZERO_EXT);
        repeat (2) @(posedge clock_in);
        #1 reset_ext = 1'b1;
        expect_seq("t3_ign", 1, 22, 10, 14, 18, C_EXT, 4, 18);

        // Test 4: mid-cycle reset pulse during REL_PERIPH.
        #2 reset_ext = 1'b0;
        #1 check("t4_pre", obs, ALL_ZERO_EXT);
        #1 reset_ext = 1'b1;
        expect_seq("t4_part", 1, 15, 10, 14, 18, C_EXT, 99, 99);
        #2 reset_ext = 1'b0;
        #1 check("t4_async", obs, ALL_ZERO_EXT);
        #2 reset_ext = 1'b1;
        #1 check("t4_rise", obs, ALL_ZERO_EXT);
        expect_seq("t4_restart", 1, 20, 10, 14, 18, C_EXT, 99, 99);

        // Test 5: external reset during SOFT restores cause 01 and warm-up.
        expect_seq("t5_soft", 0, 2, 5, 9, 13, C_SOFT, 0, 1);
        #2 reset_ext = 1'b0;
        #1 check("t5_async", obs, ALL_ZERO_EXT);
        repeat (2) @(posedge clock_in);
        #1 check("t5_held", obs, ALL_ZERO_EXT);
        reset_ext = 1'b1;
        expect_seq("t5_restart", 1, 20, 10, 14, 18, C_EXT, 99, 99);

        // Test 6: sub-cycle glitch in RUN still clears everything.
        #2 reset_ext = 1'b0;
        #1 check("t6_glitch", obs, ALL_ZERO_EXT);
        #1 reset_ext = 1'b1;
        #1 check("t6_rise", obs, ALL_ZERO_EXT);
        expect_seq("t6_restart", 1, 20, 10, 14, 18, C_EXT, 99, 99);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
